pwm_rgb: RTL and testbench

//   Three-channel 8-bit PWM generator driving the RGB LED (active-high outputs; top level inverts).

---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_channel.sv | 29 ++
 rtl/pwm_rgb.sv | 62 ++++++
 tb/tb_pwm_rgb.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared widths and types for the RGB PWM block.
package pwm_pkg;

    localparam int PWM_WIDTH    = 8;
    localparam int PWM_CHANNELS = 3;

    typedef logic [PWM_WIDTH-1:0] duty_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM lane: active-duty register, comparator against the shared counter, output flop.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm
);

    logic [WIDTH-1:0] active;

    // Compare uses the pre-load duty, so a boundary load first shows on pwm after cnt=0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (load)
                active <= duty;
            pwm <= (cnt < active);
        end
    end

endmodule

// File: rtl/pwm_rgb.sv
// Three-channel PWM with duty updates deferred to the period boundary for glitch-free fades.
module pwm_rgb
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int CHANNELS = PWM_CHANNELS
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en,
    input  logic [WIDTH-1:0]    value_input0,
    input  logic [WIDTH-1:0]    value_input1,
    input  logic [WIDTH-1:0]    value_input2,
    output logic [CHANNELS-1:0] out
);

    logic [WIDTH-1:0]                cnt;
    logic [CHANNELS-1:0][WIDTH-1:0]  vals;
    logic [CHANNELS-1:0][WIDTH-1:0]  pending;
    logic [CHANNELS-1:0][WIDTH-1:0]  load_val;
    logic                            pend_vld;
    logic                            wrap;
    logic                            load;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_vals
        assign vals[i] = (i == 0) ? value_input0 :
                         (i == 1) ? value_input1 : value_input2;
    end

    assign wrap     = (cnt == {WIDTH{1'b1}});
    assign load     = wrap && (en || pend_vld);
    // A strobe on the boundary edge bypasses the pending bank.
    assign load_val = en ? vals : pending;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            pending  <= '0;
            pend_vld <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (en)
                pending <= vals;
            if (wrap)
                pend_vld <= 1'b0;
            else if (en)
                pend_vld <= 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(.WIDTH(WIDTH)) u_ch (
            .clk    (clk),
            .resetn (resetn),
            .load   (load),
            .duty   (load_val[i]),
            .cnt    (cnt),
            .pwm    (out[i])
        );
    end

endmodule

// File: tb/tb_pwm_rgb.sv
// Self-checking bench for pwm_rgb: period-level duty model, table of duty loads, corner sequences.
module tb_pwm_rgb;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       en = 1'b0;
    logic [7:0] value_input0 = 8'd0;
    logic [7:0] value_input1 = 8'd0;
    logic [7:0] value_input2 = 8'd0;
    logic [2:0] out;

    pwm_rgb dut (
        .clk          (clk),
        .resetn       (resetn),
        .en           (en),
        .value_input0 (value_input0),
        .value_input1 (value_input1),
        .value_input2 (value_input2),
        .out          (out)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Model: each 256-edge period runs at one duty per channel; the duty for the next period
    // is whatever strobe came last during this one (boundary strobe included).
    int       edge_n;
    int       cur [3];
    int       lat [3];
    bit       lat_vld;
    logic [2:0] exp_out;

    function automatic void model_reset();
        edge_n  = 0;
        lat_vld = 0;
        for (int c = 0; c < 3; c++) begin
            cur[c] = 0;
            lat[c] = 0;
        end
        exp_out = 3'b000;
    endfunction

    function automatic int phase();
        return edge_n % 256;
    endfunction

    task automatic check(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
        end
    endtask

    // Called at negedge: drive, take one rising edge, advance model, compare at next negedge.
    task automatic step(input logic e_i, input int a, input int b, input int c);
        en = e_i;
        value_input0 = 8'(a);
        value_input1 = 8'(b);
        value_input2 = 8'(c);
        @(posedge clk);
        for (int k = 0; k < 3; k++)
            exp_out[k] = (phase() < cur[k]);
        if (e_i) begin
            lat[0] = a; lat[1] = b; lat[2] = c;
            lat_vld = 1;
        end
        if (phase() == 255) begin
            if (lat_vld)
                for (int k = 0; k < 3; k++) cur[k] = lat[k];
            lat_vld = 0;
        end
        edge_n++;
        @(negedge clk);
        check("out", int'(out), int'(exp_out));
    endtask

    task automatic idle_to_boundary();
        while (phase() != 0) step(1'b0, 0, 0, 0);
    endtask

    // Measure one full period starting at the boundary; returns high counts and R rise->fall span.
    task automatic measure(output int hi [3], output int r_span);
        int rise, fall;
        rise = -1;
        fall = -1;
        for (int c = 0; c < 3; c++) hi[c] = 0;
        for (int t = 0; t < 256; t++) begin
            step(1'b0, 0, 0, 0);
            for (int c = 0; c < 3; c++) if (out[c]) hi[c]++;
            if (out[0] && rise < 0) rise = t;
            if (!out[0] && rise >= 0 && fall < 0) fall = t;
        end
        if (rise >= 0 && fall < 0) fall = 256;
        r_span = (rise < 0) ? 0 : fall - rise;
    endtask

    typedef struct {
        int d [3];
        int exp_hi [3];
        int exp_span;
    } vec_t;

    vec_t tbl [4];
    int   hi [3];
    int   span;

    initial begin
        tbl[0] = '{d: '{128, 64, 0},  exp_hi: '{128, 64, 0},  exp_span: 128};
        tbl[1] = '{d: '{255, 1, 0},   exp_hi: '{255, 1, 0},   exp_span: 255};
        tbl[2] = '{d: '{0, 255, 17},  exp_hi: '{0, 255, 17},  exp_span: 0};
        tbl[3] = '{d: '{1, 200, 254}, exp_hi: '{1, 200, 254}, exp_span: 1};

        // Reset held with en high and all-ones inputs: outputs must stay low.
        model_reset();
        en = 1'b1;
        value_input0 = 8'hFF; value_input1 = 8'hFF; value_input2 = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_out", int'(out), 0);
        end
        en = 1'b0;
        resetn = 1'b1;
        model_reset();

        // No load yet: a full period of zero duty.
        for (int i = 0; i < 256; i++) step(1'b0, 0, 0, 0);

        // Table: load mid-period, wait for boundary, count highs over one period.
        foreach (tbl[i]) begin
            repeat (1 + $urandom_range(0, 40)) step(1'b0, 0, 0, 0);
            step(1'b1, tbl[i].d[0], tbl[i].d[1], tbl[i].d[2]);
            idle_to_boundary();
            measure(hi, span);
            for (int c = 0; c < 3; c++)
                check($sformatf("tbl%0d_hi%0d", i, c), hi[c], tbl[i].exp_hi[c]);
            check($sformatf("tbl%0d_rspan", i), span, tbl[i].exp_span);
        end

        // Two strobes in one period: current period keeps its duty, next uses the last strobe.
        step(1'b1, 40, 40, 40);
        idle_to_boundary();
        while (phase() != 50) step(1'b0, 0, 0, 0);
        step(1'b1, 200, 200, 200);
        while (phase() != 100) step(1'b0, 0, 0, 0);
        step(1'b1, 10, 10, 10);
        hi[0] = 0;
        while (phase() != 0) begin
            step(1'b0, 0, 0, 0);
            if (out[0]) hi[0]++;
        end
        check("last_wins_cur_tail", hi[0], 0);
        measure(hi, span);
        check("last_wins_next", hi[0], 10);

        // Strobe exactly on the boundary edge loads straight through.
        while (phase() != 255) step(1'b0, 0, 0, 0);
        step(1'b1, 77, 77, 77);
        measure(hi, span);
        check("bypass_hi", hi[1], 77);

        // Randomized strobes, including held-high runs, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                repeat ($urandom_range(1, 6))
                    step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            else if ($urandom_range(0, 63) == 0)
                begin
                    while (phase() != 255) step(1'b0, 0, 0, 0);
                    step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
                end
            else
                step(1'b0, 0, 0, 0);
        end

        // Async reset mid-period with all outputs high.
        step(1'b1, 100, 100, 100);
        idle_to_boundary();
        while (phase() != 30) step(1'b0, 0, 0, 0);
        check("pre_reset_out", int'(out), 7);
        #2 resetn = 1'b0;
        #1 check("async_reset_out", int'(out), 0);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 300; i++) step(1'b0, 0, 0, 0);
        step(1'b1, 33, 66, 99);
        idle_to_boundary();
        measure(hi, span);
        check("post_reset_r", hi[0], 33);
        check("post_reset_g", hi[1], 66);
        check("post_reset_b", hi[2], 99);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
